// File: rtl/oam_dma.sv
// Sprite OAM DMA initiator: snoops CPU writes to $4014, halts the CPU and copies
// one 256-byte CPU page into SPRAM through $2004 as read/write pairs.
module oam_dma #(
  parameter int HALT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en_in,
  output logic        cpu_ready,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  output logic        dma_write_en,
  output logic        dma_read_en,
  input  logic [7:0]  dma_data_in,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_RD,
    S_RDW,
    S_WR,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  idx_q;
  logic [7:0]  page_q;
  logic [7:0]  byte_buf_q;
  logic        parity_q;
  logic        align_q;
  logic [2:0]  cnt_q;
  logic        cpu_ready_q;
  logic        dma_active_q;
  logic [15:0] dma_addr_q;
  logic        dma_write_en_q;
  logic        dma_read_en_q;
  logic        dma_done_q;

  logic [2:0]  halt_len;
  logic        trigger;

  // An odd-parity trigger stretches the halt by one cycle to realign with the bus.
  assign halt_len = 3'(HALT_CYCLES) + {2'b00, align_q};
  assign trigger  = cpu_write_en_in && (cpu_addr_in == 16'h4014);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      idx_q          <= 8'h00;
      page_q         <= 8'h00;
      byte_buf_q     <= 8'h00;
      parity_q       <= 1'b0;
      align_q        <= 1'b0;
      cnt_q          <= 3'd0;
      cpu_ready_q    <= 1'b1;
      dma_active_q   <= 1'b0;
      dma_addr_q     <= 16'h0000;
      dma_write_en_q <= 1'b0;
      dma_read_en_q  <= 1'b0;
      dma_done_q     <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            page_q      <= cpu_data_in;
            align_q     <= parity_q;
            idx_q       <= 8'h00;
            cnt_q       <= 3'd0;
            cpu_ready_q <= 1'b0;
            state_q     <= S_HALT;
          end
        end
        S_HALT: begin
          if (cnt_q + 3'd1 >= halt_len) begin
            dma_active_q  <= 1'b1;
            dma_addr_q    <= {page_q, idx_q};
            dma_read_en_q <= 1'b1;
            state_q       <= S_RD;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_RD: begin
          dma_read_en_q <= 1'b0;
          state_q       <= S_RDW;
        end
        S_RDW: begin
          // Decoder RAM is synchronous: data for the RD address is valid now.
          byte_buf_q     <= dma_data_in;
          dma_addr_q     <= 16'h2004;
          dma_write_en_q <= 1'b1;
          state_q        <= S_WR;
        end
        S_WR: begin
          dma_write_en_q <= 1'b0;
          idx_q          <= idx_q + 8'h01;
          if (idx_q == 8'hFF) begin
            dma_active_q <= 1'b0;
            dma_addr_q   <= 16'h0000;
            cpu_ready_q  <= 1'b1;
            dma_done_q   <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            dma_addr_q    <= {page_q, idx_q + 8'h01};
            dma_read_en_q <= 1'b1;
            state_q       <= S_RD;
          end
        end
        S_DONE: begin
          dma_done_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready    = cpu_ready_q;
  assign dma_active   = dma_active_q;
  assign dma_addr     = dma_addr_q;
  assign dma_data_out = byte_buf_q;
  assign dma_write_en = dma_write_en_q;
  assign dma_read_en  = dma_read_en_q;
  assign dma_done     = dma_done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: models the memory decoder (sync CPU RAM, $2003/$2004 OAM port)
// and scoreboards every OAM write against the source page.
module tb_oam_dma;
  localparam int HALT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr_in = 16'h0000;
  logic [7:0]  cpu_data_in = 8'h00;
  logic        cpu_write_en_in = 1'b0;
  logic        cpu_ready;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic        dma_write_en;
  logic        dma_read_en;
  logic [7:0]  dma_data_in;
  logic        dma_done;

  always #5 clk = ~clk;

  oam_dma #(.HALT_CYCLES(HALT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .cpu_write_en_in(cpu_write_en_in),
    .cpu_ready(cpu_ready), .dma_active(dma_active), .dma_addr(dma_addr),
    .dma_data_out(dma_data_out), .dma_write_en(dma_write_en), .dma_read_en(dma_read_en),
    .dma_data_in(dma_data_in), .dma_done(dma_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decoder model
  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];
  logic [7:0] oam_addr = 8'h00;
  logic [7:0] rdata = 8'h00;
  logic       oam_fill = 1'b0;

  always @(posedge clk) begin
    if (oam_fill) begin
      for (int i = 0; i < 256; i++) oam[i] <= 8'hEE;
    end else begin
      if (dma_active && dma_read_en) rdata <= mem[dma_addr];
      if (dma_active && dma_write_en && dma_addr == 16'h2004) begin
        oam[oam_addr] <= dma_data_out;
        oam_addr      <= oam_addr + 8'h01;
      end
      if (!dma_active && cpu_write_en_in && cpu_addr_in == 16'h2003) oam_addr <= cpu_data_in;
    end
  end
  assign dma_data_in = rdata;

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Monitor and scoreboard
  logic [7:0] sbq [$];
  int wr_cnt = 0, done_cnt = 0, rdy_low = 0, overlap = 0, stray = 0, first_rd = 0;
  logic prev_active = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (!cpu_ready) rdy_low++;
      if (dma_done) done_cnt++;
      if (dma_read_en && dma_write_en) overlap++;
      if (!dma_active && (dma_read_en || dma_write_en)) stray++;
      if (dma_read_en && !prev_active) first_rd = cyc;
      if (dma_write_en) begin
        wr_cnt++;
        check("wr_addr", {16'h0, dma_addr}, 32'h2004);
        if (sbq.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("wr_data", {24'h0, dma_data_out}, {24'h0, sbq.pop_front()});
      end
      prev_active = dma_active;
    end
  end

  logic [7:0] exp_oam [0:255];
  int trig_cyc, align_b, rl0, done0, wr0;

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic we);
    cpu_addr_in = a; cpu_data_in = d; cpu_write_en_in = we;
    tick();
    cpu_write_en_in = 1'b0; cpu_addr_in = 16'h0000; cpu_data_in = 8'h00;
  endtask

  task automatic fill_oam();
    oam_fill = 1'b1;
    tick();
    oam_fill = 1'b0;
  endtask

  task automatic wait_parity(input int p);
    while ((cyc & 1) != p) tick();
  endtask

  task automatic start(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      sbq.push_back(mem[{page, 8'(i)}]);
      exp_oam[8'(oam_addr + 8'(i))] = mem[{page, 8'(i)}];
    end
    trig_cyc = cyc;
    align_b  = cyc & 1;
    rl0 = rdy_low; done0 = done_cnt; wr0 = wr_cnt;
    cpu_op(16'h4014, page, 1'b1);
  endtask

  task automatic finish(input string tag, input bit tamper);
    int k = 0;
    int mism = 0;
    while (done_cnt == done0 && k < 3000) begin
      if (tamper && k == 60) begin
        cpu_addr_in = 16'h4014; cpu_data_in = 8'h07; cpu_write_en_in = 1'b1;
      end
      if (tamper && k == 61) begin
        cpu_addr_in = 16'h0000; cpu_data_in = 8'h00; cpu_write_en_in = 1'b0;
      end
      tick();
      k++;
    end
    cpu_write_en_in = 1'b0;
    if (done_cnt == done0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    repeat (4) tick();
    check({tag, "_latency"}, first_rd - trig_cyc, HALT_CYCLES + align_b + 1);
    check({tag, "_ready_low"}, rdy_low - rl0, HALT_CYCLES + align_b + 768);
    check({tag, "_done"}, done_cnt - done0, 1);
    check({tag, "_writes"}, wr_cnt - wr0, 256);
    check({tag, "_sb_left"}, sbq.size(), 0);
    check({tag, "_ready_after"}, {31'h0, cpu_ready}, 32'd1);
    for (int i = 0; i < 256; i++) if (oam[i] !== exp_oam[i]) mism++;
    check({tag, "_oam"}, mism, 0);
  endtask

  initial begin
    int k, nz, d_base, w_base;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0300 + i] = 8'hFF - 8'(i);
    end
    #1 rst = 1'b0;
    #1;
    check("rst_cpu_ready", {31'h0, cpu_ready}, 32'd1);
    check("rst_dma_active", {31'h0, dma_active}, 32'd0);
    check("rst_dma_addr", {16'h0, dma_addr}, 32'd0);
    check("rst_dma_data", {24'h0, dma_data_out}, 32'd0);
    check("rst_we", {31'h0, dma_write_en}, 32'd0);
    check("rst_re", {31'h0, dma_read_en}, 32'd0);
    check("rst_done", {31'h0, dma_done}, 32'd0);
    tick();
    fill_oam();
    tick();
    rst = 1'b1;
    tick();

    // Writes/reads that must not trigger
    cpu_op(16'h4015, 8'h02, 1'b1);
    cpu_op(16'h4013, 8'h02, 1'b1);
    cpu_op(16'h4014, 8'h02, 1'b0);
    repeat (5) tick();
    check("notrig_ready_low", rdy_low, 0);
    check("notrig_active", {31'h0, dma_active}, 32'd0);
    check("notrig_ready", {31'h0, cpu_ready}, 32'd1);

    // Even-parity trigger
    cpu_op(16'h2003, 8'h00, 1'b1);
    wait_parity(0);
    start(8'h02);
    finish("even", 1'b0);

    // Odd-parity trigger
    fill_oam();
    cpu_op(16'h2003, 8'h00, 1'b1);
    wait_parity(1);
    start(8'h02);
    finish("odd", 1'b0);

    // Non-zero OAM start address
    fill_oam();
    cpu_op(16'h2003, 8'h10, 1'b1);
    start(8'h03);
    finish("oam10", 1'b0);
    check("oam10_first", {24'h0, oam[8'h10]}, 32'hFF);
    check("oam10_last", {24'h0, oam[8'h0F]}, 32'h00);

    // $4014 write during an active transfer is ignored
    fill_oam();
    cpu_op(16'h2003, 8'h00, 1'b1);
    start(8'h02);
    finish("tamper", 1'b1);

    // Reset in the WR state of byte 100
    fill_oam();
    cpu_op(16'h2003, 8'h00, 1'b1);
    start(8'h02);
    k = 0;
    while (!(wr_cnt - wr0 == 100 && dma_write_en) && k < 2000) begin
      tick();
      k++;
    end
    check("midrst_reached", {31'h0, dma_write_en}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_ready", {31'h0, cpu_ready}, 32'd1);
    check("midrst_active", {31'h0, dma_active}, 32'd0);
    check("midrst_addr", {16'h0, dma_addr}, 32'd0);
    check("midrst_data", {24'h0, dma_data_out}, 32'd0);
    check("midrst_we", {31'h0, dma_write_en}, 32'd0);
    check("midrst_re", {31'h0, dma_read_en}, 32'd0);
    check("midrst_done", {31'h0, dma_done}, 32'd0);
    sbq.delete();
    repeat (4) tick();
    check("midrst_writes", wr_cnt - wr0, 100);
    nz = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== 8'hEE) nz++;
    check("midrst_oam_count", nz, 100);
    check("midrst_oam99", {24'h0, oam[99]}, {24'h0, 8'd99 ^ 8'h5A});
    rst = 1'b1;
    tick();
    fill_oam();
    cpu_op(16'h2003, 8'h00, 1'b1);
    start(8'h03);
    finish("after_rst", 1'b0);

    // Back-to-back: second trigger in the cycle right after DONE
    fill_oam();
    cpu_op(16'h2003, 8'h00, 1'b1);
    d_base = done_cnt;
    w_base = wr_cnt;
    start(8'h02);
    k = 0;
    while (done_cnt == d_base && k < 3000) begin
      tick();
      k++;
    end
    start(8'h03);
    finish("b2b", 1'b0);
    check("b2b_done_total", done_cnt - d_base, 2);
    check("b2b_writes_total", wr_cnt - w_base, 512);

    check("strobe_overlap", overlap, 0);
    check("strobe_inactive", stray, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Bus-master initiator for sprite OAM DMA. It watches CPU writes for $4014, then halts the CPU.
- It copies 256 bytes from CPU page {page,8'h00}..{page,8'hFF} into SPRAM by issuing 256 read/write pairs on the memory decoder's CPU-side bus. Each byte is read from CPU space and written to $2004.
- It sits between the CPU core and the memory decoder. The system bus mux selects dma_* signals whenever dma_active=1.

Parameters:
- HALT_CYCLES, 1, fixed dummy cycles between trigger and first DMA read (range 1..3).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- cpu_addr_in  input  16  CPU-issued address (snooped)
- cpu_data_in  input  8  CPU-issued write data (snooped)
- cpu_write_en_in  input  1  CPU write strobe (snooped)
- cpu_ready  output  1  1 = CPU may run; 0 = CPU halted
- dma_active  output  1  1 = bus mux selects dma_* signals
- dma_addr  output  16  master address to memory decoder
- dma_data_out  output  8  master write data to memory decoder
- dma_write_en  output  1  master write strobe
- dma_read_en  output  1  master read strobe
- dma_data_in  input  8  read data returned by decoder (its cpu_data_out)
- dma_done  output  1  one-cycle pulse at transfer completion

Behaviour:
- Reset values:
  - cpu_ready=1; dma_active=0; dma_addr=0; dma_data_out=0; dma_write_en=0; dma_read_en=0; dma_done=0.
  - state=IDLE; idx=0; page=0; byte_buf=0; parity=0.
- parity: free-running 1-bit toggle every clk after reset.
- All outputs are Moore, registered or decoded from state registers only. There is no combinational path from any input to any output.
- Trigger:
  - Condition: in IDLE, cpu_write_en_in=1 && cpu_addr_in==16'h4014 exactly.
  - Action: latch page<=cpu_data_in, align<=parity, idx<=0, wait counter<=0; next HALT.
  - Non-trigger cases: $4014 writes in any other state are ignored. Reads of $4014 and writes to $4015/$4013 never trigger.
- States:
  - IDLE: cpu_ready=1, dma_active=0.
  - HALT:
    - cpu_ready=0, dma_active=0, no strobes.
    - Stays HALT_CYCLES+align cycles (counter), then goes to RD.
    - Odd-parity trigger therefore costs one extra cycle.
  - RD: cpu_ready=0, dma_active=1, dma_addr={page,idx}, dma_read_en=1; next RDW.
  - RDW:
    - dma_active=1, dma_addr={page,idx} held, dma_read_en=0.
    - byte_buf<=dma_data_in at end of cycle; decoder RAM read is synchronous, so data is valid one cycle after address.
    - Next WR.
  - WR:
    - dma_active=1, dma_addr=16'h2004, dma_data_out=byte_buf, dma_write_en=1.
    - idx<=idx+1 (8-bit).
    - If idx==8'hFF, go to DONE, else go to RD.
  - DONE: cpu_ready=1, dma_active=0, dma_done=1 for exactly this cycle; next IDLE.
- Timing:
  - Per byte: 3 cycles.
  - cpu_ready low for HALT_CYCLES+align+768 cycles; with default, 769 (even) or 770 (odd).
  - First DMA read occurs HALT_CYCLES+align+1 cycles after the trigger edge.
- dma_write_en and dma_read_en are never high simultaneously. Both are low whenever dma_active=0.
- Address wrap:
  - idx wraps 8'hFF->8'h00 only on the final WR; page never increments.
  - OAM destination address and its wrap belong to the decoder's $2003/$2004 logic. This block always writes 256 times starting from whatever OAM address is current.
- Source page: any page 0x00..0xFF is issued unmodified, including register/mirror pages. Side effects of such reads are the decoder's concern.
- Reset mid-operation: asynchronous return to reset values and IDLE; cpu_ready=1 immediately on assertion. No partial-transfer resume.
- Trigger coincident with reset release: ignored. The first sampled edge after rst deasserts is the earliest trigger.

Test Plan:
1. Even-parity trigger. Setup: preload CPU RAM $0200+i = i^8'h5A; OAM addr=0; write $4014=8'h02 on a parity=0 cycle. Required response:
   - OAM[i]=i^8'h5A for all 256 entries.
   - cpu_ready low exactly 769 cycles.
   - Exactly 256 dma_write_en pulses, all at dma_addr=16'h2004.
   - dma_done one pulse.
2. Odd-parity trigger. Stimulus: same as scenario 1 but trigger on a parity=1 cycle. Required response: cpu_ready low 770 cycles; first dma_read_en 3 cycles after trigger edge; data identical.
3. Non-zero OAM start. Setup: $2003=8'h10, then $4014=8'h03, with source $0300+i=8'hFF-i. Required response: OAM[(8'h10+i)&8'hFF]=8'hFF-i; last write lands in OAM[8'h0F].
4. Reset mid-transfer. Stimulus: assert rst at byte 100 (state WR). Required response:
   - All outputs return to reset values within the same cycle.
   - OAM[0..99] written, and no further writes occur.
   - A new $4014 after release performs a full 256-byte transfer.
5. Non-trigger and ignored writes. Stimulus: CPU writes to $4015 and $4013, and a CPU read of $4014. Required response: no state change and cpu_ready stays 1. Also force cpu_write_en_in/$4014 during an active transfer: the transfer is unaffected and page is unchanged.
6. Back-to-back DMA. Stimulus: a $4014 write the cycle after DONE. Required response: accepted; second transfer is complete and correct; dma_done pulses twice; no strobe overlap at any time.
